// File: rtl/iob_plic_irq_conditioner.sv
// rtl/iob_plic_irq_conditioner.sv - per-source sync, polarity, glitch filter and mask ahead of the PLIC src input
// Each source is synchronised, polarity-corrected and debounced, then masked.
// Accepted rising edges and aborted transitions are reported for diagnostics.
module iob_plic_irq_conditioner #(
  parameter int N_SOURCES   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic [N_SOURCES-1:0] irq_i,
  input  logic [N_SOURCES-1:0] pol_i,
  input  logic [N_SOURCES-1:0] en_i,
  input  logic [FILTER_W-1:0]  filter_len_i,
  input  logic [N_SOURCES-1:0] glitch_clr_i,
  output logic [N_SOURCES-1:0] src_o,
  output logic [N_SOURCES-1:0] rise_o,
  output logic [N_SOURCES-1:0] glitch_o
);

  localparam logic [FILTER_W-1:0] CNT_ONE = {{(FILTER_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0][N_SOURCES-1:0] sync_q, sync_d;
  logic [N_SOURCES-1:0][FILTER_W-1:0]    cnt_q, cnt_d;
  logic [N_SOURCES-1:0]                  filt_q, filt_d;
  logic [N_SOURCES-1:0]                  rise_q, rise_d;
  logic [N_SOURCES-1:0]                  glitch_q, glitch_d;
  logic [N_SOURCES-1:0]                  glitch_set;
  logic [N_SOURCES-1:0]                  raw;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
  assign raw    = sync_q[SYNC_STAGES-1] ^ pol_i;

  // cnt counts consecutive samples disagreeing with filt; a return to
  // agreement while counting is an aborted transition.
  always_comb begin
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    glitch_set = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      if (raw[i] == filt_q[i]) begin
        cnt_d[i]      = '0;
        glitch_set[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] >= filter_len_i) begin
        filt_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign rise_d   = filt_d & ~filt_q & en_i;
  assign glitch_d = glitch_set | (glitch_q & ~glitch_clr_i);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= '0;
      rise_q   <= '0;
      glitch_q <= '0;
    end else if (cke_i) begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      glitch_q <= glitch_d;
    end
  end

  assign src_o    = filt_q & en_i;
  assign rise_o   = rise_q;
  assign glitch_o = glitch_q;

endmodule

// File: tb/tb_iob_plic_irq_conditioner.sv
// tb/tb_iob_plic_irq_conditioner.sv - streak-based reference model plus directed edge-count checks
module tb_iob_plic_irq_conditioner;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          cke;
  logic [N-1:0]  irq, pol, en, clr;
  logic [FW-1:0] flen;
  logic [N-1:0]  src_o, rise_o, glitch_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iob_plic_irq_conditioner #(.N_SOURCES(N), .SYNC_STAGES(SS), .FILTER_W(FW)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .irq_i(irq), .pol_i(pol), .en_i(en),
    .filter_len_i(flen), .glitch_clr_i(clr), .src_o(src_o), .rise_o(rise_o), .glitch_o(glitch_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a source's level flips once L+1 consecutive post-sync samples
  // disagree with it; a disagreeing streak that ends early is a glitch.
  logic [N-1:0] m_pipe [SS];
  logic [N-1:0] m_filt, m_rise, m_glitch, m_raw, m_prev, m_set;
  int           m_streak [N];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = '0;
      for (int i = 0; i < N; i++) m_streak[i] = 0;
      m_filt = '0; m_rise = '0; m_glitch = '0;
    end else if (cke) begin
      m_raw  = m_pipe[SS-1] ^ pol;
      m_prev = m_filt;
      m_set  = '0;
      for (int i = 0; i < N; i++) begin
        if (m_raw[i] !== m_filt[i]) begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] > int'(flen)) begin
            m_filt[i]   = m_raw[i];
            m_streak[i] = 0;
          end
        end else begin
          if (m_streak[i] != 0) m_set[i] = 1'b1;
          m_streak[i] = 0;
        end
      end
      m_rise   = m_filt & ~m_prev & en;
      m_glitch = m_set | (m_glitch & ~clr);
      for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = irq;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("model_src", src_o, m_filt & en);
    chk("model_rise", rise_o, m_rise);
    chk("model_glitch", glitch_o, m_glitch);
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int rises;

  initial begin
    arst = 1'b1; cke = 1'b1; irq = '0; pol = 8'h01; en = '1; clr = '0; flen = 4'd3;
    wait_edges(1);
    chk("t1_src_in_reset", src_o, 8'h00);
    chk("t1_rise_in_reset", rise_o, 8'h00);

    // reset release with active-low source 0
    @(negedge clk) arst = 1'b0;
    rises = 0;
    for (int e = 0; e < 6; e++) begin
      wait_edges(1);
      if (rise_o[0]) rises++;
    end
    chk("t1_src0_edge6", src_o[0], 1'b1);
    chk("t1_rise0_count", rises, 1);
    wait_edges(3);

    // accepted pulse on source 2
    @(negedge clk) irq[2] = 1'b1;
    wait_edges(5);
    chk("t2_src2_edge5", src_o[2], 1'b0);
    wait_edges(1);
    chk("t2_src2_edge6", src_o[2], 1'b1);
    chk("t2_rise2_edge6", rise_o[2], 1'b1);
    wait_edges(1);
    chk("t2_rise2_edge7", rise_o[2], 1'b0);
    wait_edges(3);
    @(negedge clk) irq[2] = 1'b0;
    wait_edges(5);
    chk("t2_src2_fall5", src_o[2], 1'b1);
    wait_edges(1);
    chk("t2_src2_fall6", src_o[2], 1'b0);
    chk("t2_glitch", glitch_o, 8'h00);
    wait_edges(2);

    // two-cycle glitch on source 5, then clear, then set-wins-over-clear
    @(negedge clk) irq[5] = 1'b1;
    @(negedge clk);
    @(negedge clk) irq[5] = 1'b0;
    wait_edges(6);
    chk("t3_src5", src_o[5], 1'b0);
    chk("t3_glitch5", glitch_o[5], 1'b1);
    @(negedge clk) clr[5] = 1'b1;
    wait_edges(1);
    chk("t3_glitch5_clr", glitch_o[5], 1'b0);
    @(negedge clk) clr[5] = 1'b0;
    @(negedge clk) irq[5] = 1'b1;
    @(negedge clk);
    @(negedge clk) irq[5] = 1'b0;
    @(negedge clk);
    @(negedge clk) clr[5] = 1'b1;
    wait_edges(1);
    chk("t3_set_wins", glitch_o[5], 1'b1);
    @(negedge clk) clr[5] = 1'b0;
    wait_edges(3);

    // masked source 1, later unmasked while high
    @(negedge clk) begin en[1] = 1'b0; irq[1] = 1'b1; end
    wait_edges(8);
    chk("t4_src1_masked", src_o[1], 1'b0);
    @(negedge clk) en[1] = 1'b1;
    #1;
    chk("t4_src1_unmask", src_o[1], 1'b1);
    chk("t4_rise1_unmask", rise_o[1], 1'b0);
    wait_edges(1);
    chk("t4_rise1_after", rise_o[1], 1'b0);
    @(negedge clk) irq[1] = 1'b0;
    wait_edges(8);

    // clock-enable freeze with cnt=2 on source 3
    @(negedge clk) irq[3] = 1'b1;
    wait_edges(4);
    @(negedge clk) cke = 1'b0;
    for (int e = 0; e < 5; e++) begin
      wait_edges(1);
      chk("t5_src3_frozen", src_o[3], 1'b0);
    end
    @(negedge clk) cke = 1'b1;
    wait_edges(1);
    chk("t5_src3_resume1", src_o[3], 1'b0);
    wait_edges(1);
    chk("t5_src3_resume2", src_o[3], 1'b1);
    chk("t5_rise3", rise_o[3], 1'b1);
    @(negedge clk) cke = 1'b0;
    wait_edges(2);
    chk("t5_rise3_held", rise_o[3], 1'b1);
    @(negedge clk) cke = 1'b1;
    wait_edges(1);
    chk("t5_rise3_drop", rise_o[3], 1'b0);
    @(negedge clk) irq[3] = 1'b0;
    wait_edges(8);

    // reset with cnt=2 on source 4 restarts the full latency
    @(negedge clk) irq[4] = 1'b1;
    wait_edges(4);
    @(negedge clk) arst = 1'b1;
    #1;
    chk("t5_reset_src", src_o, 8'h00);
    chk("t5_reset_glitch", glitch_o, 8'h00);
    @(negedge clk) arst = 1'b0;
    wait_edges(5);
    chk("t5_src4_edge5", src_o[4], 1'b0);
    wait_edges(1);
    chk("t5_src4_edge6", src_o[4], 1'b1);
    @(negedge clk) irq[4] = 1'b0;
    wait_edges(8);

    // L=0 bypass: one-cycle pulse on source 6
    @(negedge clk) begin flen = 4'd0; irq[6] = 1'b1; end
    @(negedge clk) irq[6] = 1'b0;
    wait_edges(1);
    chk("t6_src6_e1", src_o[6], 1'b0);
    wait_edges(1);
    chk("t6_src6_e2", src_o[6], 1'b1);
    chk("t6_rise6_e2", rise_o[6], 1'b1);
    wait_edges(1);
    chk("t6_src6_e3", src_o[6], 1'b0);
    chk("t6_glitch6", glitch_o[6], 1'b0);
    wait_edges(3);

    // L lowered 7 -> 1 with cnt=4 on source 7
    @(negedge clk) begin flen = 4'd7; irq[7] = 1'b1; end
    wait_edges(6);
    chk("t6_src7_cnt4", src_o[7], 1'b0);
    @(negedge clk) flen = 4'd1;
    wait_edges(1);
    chk("t6_src7_accept", src_o[7], 1'b1);
    chk("t6_rise7_accept", rise_o[7], 1'b1);
    wait_edges(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
